// File: rtl/clk_pkg.sv
// Shared constants and direction encoding for the digital clock datapath.
// Default dividers and moduli describe the hour digit driven from a seconds prescaler.
package clk_pkg;

  localparam int SEC_PRE_DIV = 3600;
  localparam int SEC_PRE_W   = 12;
  localparam int HOUR_MOD    = 5;
  localparam int HOUR_W      = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : clk_pkg

// File: rtl/cnt_prescaler.sv
// Free-running divide-by-PRE_DIV prescaler; tc is a combinational terminal-count strobe
// that is valid for the cycle in which the counter wraps back to zero.
module cnt_prescaler
  import clk_pkg::*;
#(
  parameter int PRE_DIV = SEC_PRE_DIV,
  parameter int PRE_W   = SEC_PRE_W
) (
  input  logic in_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [PRE_W-1:0] CNT_LAST = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    tc    = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tc    = 1'b1;
      end else begin
        cnt_d = cnt_q + PRE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : cnt_prescaler

// File: rtl/cnt_mod_prescale.sv
// Prescaled modulo-MOD digit counter with synchronous load, manual set-mode stepping
// and a one-cycle carry/borrow pulse for cascading into the next digit.
module cnt_mod_prescale
  import clk_pkg::*;
#(
  parameter int PRE_DIV = SEC_PRE_DIV,
  parameter int PRE_W   = SEC_PRE_W,
  parameter int MOD     = HOUR_MOD,
  parameter int W       = HOUR_W
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] q,
  output logic         tick,
  output logic         carry
);

  localparam logic [W-1:0] Q_LAST = W'(MOD - 1);

  logic         tc;
  dir_e         dir_s;
  logic [W-1:0] q_q, q_d;
  logic         tick_q, tick_d;
  logic         carry_q, carry_d;
  logic [W-1:0] q_up, q_down, q_clamped;
  logic         wrap_up, wrap_down;

  // A load restarts the prescale interval so the next tick is a full period away.
  cnt_prescaler #(
    .PRE_DIV (PRE_DIV),
    .PRE_W   (PRE_W)
  ) u_prescaler (
    .in_clk (in_clk),
    .rst    (rst),
    .en     (en),
    .clr    (load),
    .tc     (tc)
  );

  assign dir_s = dir_e'(dir);

  // Explicit compare-to-limit keeps q inside 0..MOD-1 even when MOD is not a power of two.
  assign wrap_up   = (q_q == Q_LAST);
  assign wrap_down = (q_q == '0);
  assign q_up      = wrap_up   ? '0     : q_q + W'(1);
  assign q_down    = wrap_down ? Q_LAST : q_q - W'(1);
  assign q_clamped = (load_val > Q_LAST) ? Q_LAST : load_val;

  always_comb begin
    q_d     = q_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (load) begin
      q_d = q_clamped;
    end else begin
      tick_d = tc;
      if (step) begin
        // Set-mode steps never carry, so adjusting one digit leaves its neighbour alone.
        q_d = (dir_s == DIR_UP) ? q_up : q_down;
      end else if (tc) begin
        if (dir_s == DIR_UP) begin
          q_d     = q_up;
          carry_d = wrap_up;
        end else begin
          q_d     = q_down;
          carry_d = wrap_down;
        end
      end
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign q     = q_q;
  assign tick  = tick_q;
  assign carry = carry_q;

endmodule : cnt_mod_prescale

// File: doc/cnt_mod_prescale.md
# cnt_mod_prescale

Parametrised prescaled modulo counter for the digital clock datapath. A free-running prescaler divides `in_clk` by `PRE_DIV`. Each prescaler terminal count steps a modulo-`MOD` digit up or down. The block supports synchronous load, manual set-mode stepping and a one-cycle carry/borrow output, so digits (seconds, minutes, hours) can be cascaded and set from buttons.

## Interface
Parameters:
- `PRE_DIV`, 3600: prescaler division ratio; must be ≥ 1.
- `PRE_W`, 12: prescaler width; must satisfy 2^PRE_W ≥ PRE_DIV.
- `MOD`, 5: digit modulus; `q` ranges 0..MOD-1; must be ≥ 2.
- `W`, 4: digit width; must satisfy 2^W ≥ MOD.

Ports:
- `in_clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: count enable; gates prescaler advance.
- `dir`  in  1: 1 = count up, 0 = count down.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  W: value loaded on `load`.
- `step`  in  1: single-cycle manual step pulse (set mode), independent of `en`.
- `q`  out  W: current digit value.
- `tick`  out  1: one-cycle pulse; prescaler reached terminal count this cycle.
- `carry`  out  1: one-cycle pulse; `q` wrapped due to a prescaled step.

## Operation
- Reset (async, `rst`=1): prescaler = 0, `q` = 0, `tick` = 0, `carry` = 0. State holds at these values while `rst` is high.
- Prescaler:
  - Counts 0..PRE_DIV-1 while `en`=1 and holds while `en`=0.
  - At PRE_DIV-1 with `en`=1, it returns to 0 and raises the internal terminal-count pulse `tc`.
  - With PRE_DIV=1, `tc` is asserted on every enabled cycle.
- Priority per cycle: `load` > `step` > `tc`.
- Load:
  - `q` ← `load_val`; a value ≥ MOD is clamped to MOD-1.
  - Prescaler is cleared to 0. `tc` is suppressed that cycle and `carry` is 0.
- Step (`load`=0, `step`=1):
  - `q` steps one place in the direction set by `dir`, with modulo wrap.
  - `carry` is 0 even on wrap, so setting one digit never bumps the next.
  - The prescaler advances normally. A coincident `tc` is absorbed and `q` moves only one step.
- Prescaled step (`tc`=1, no `load`/`step`):
  - Up: `q`==MOD-1 → 0 with `carry`=1; otherwise `q`+1.
  - Down: `q`==0 → MOD-1 with `carry`=1 (borrow); otherwise `q`-1.
- `tick` mirrors `tc`, including when absorbed by `step`. It is 0 on load cycles.
- `dir` is sampled on the stepping edge. Changing it mid-prescale has no other effect.
- All arithmetic is on W/PRE_W bits with explicit compare-to-limit. `q` never leaves 0..MOD-1.

## Timing
- All outputs are registered. `q`, `tick` and `carry` update on the same edge.
- `tick` and `carry` are high for exactly one `in_clk` cycle.
- With `en` held high from reset release, the first `tick` appears PRE_DIV cycles after the first rising edge with `rst`=0. Subsequent ticks follow every PRE_DIV cycles.
- Load/step latency: 1 cycle; the new `q` is visible after the sampling edge.
- `rst` asserted mid-count: outputs go to 0 immediately, asynchronously. Counting restarts from prescaler 0 on release.
- Cascading: the downstream block's `en` connects to the upstream `carry`, with that block's PRE_DIV=1.

## Structure
- Shared package `clk_pkg`: default constants `SEC_PRE_DIV`=3600 and `HOUR_MOD`=5, plus a `dir_e` encoding (`DIR_DOWN`=0, `DIR_UP`=1).
- Sub-module `cnt_prescaler` (params `PRE_DIV`, `PRE_W`; ports `in_clk`, `rst`, `en`, `clr`, `tc`) holds the divider.
- The top level contains the digit register, priority mux, clamp and output registers.

## Test plan
All scenarios use PRE_DIV=4, MOD=5, W=4, PRE_W=2.
- Reset released, `en`=1, `dir`=1 for 40 cycles → `tick` every 4 cycles. `q` runs 0,1,2,3,4,0. `carry` is high for 1 cycle exactly when `q` returns 0.
- `dir`=0 from `q`=0, `en`=1 → on the next `tick`, `q`=4 and `carry`=1. On the following tick, `q`=3 and `carry`=0.
- `load`=1 with `load_val`=7 mid-prescale → next cycle `q`=4, prescaler=0, `tick`=0. The next `tick` comes 4 cycles later.
- `en`=0, `step` pulsed 6 times with `dir`=1 from `q`=3 → `q`=4,0,1,2,3,4; `carry` stays 0 and `tick` stays 0.
- `step` coincident with `tc`, `q`=2, `dir`=1 → `q`=3 (single step), `tick`=1, `carry`=0. `load` and `step` together with `load_val`=1 → `q`=1.
- `rst` asserted asynchronously between edges while `q`=3 → `q`=0, `tick`=0, `carry`=0 before the next edge. After release, the first `tick` comes 4 cycles later.
